// File: rtl/lemming_bridge_arbiter_if.sv
// Request/grant bundle between the per-lemming walk FSMs (master) and the
// bridge arbiter (slave).
interface lemming_bridge_arbiter_if #(
  parameter int N = 4
) ();
  logic [N-1:0] req;
  logic [N-1:0] dir;
  logic [N-1:0] grant;
  logic         cross_dir;
  logic         busy;
  logic         done;

  modport master (
    output req,
    output dir,
    input  grant,
    input  cross_dir,
    input  busy,
    input  done
  );

  modport slave (
    input  req,
    input  dir,
    output grant,
    output cross_dir,
    output busy,
    output done
  );
endinterface

// File: rtl/lemming_bridge_arbiter.sv
// Round-robin arbiter sharing a one-lane bridge among N lemmings, holding each
// grant for a fixed crossing time and inserting a gap on direction reversal.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | bridge empty, no grant; any request starts a crossing next cycle
// CROSS  | one lemming owns the bridge; counter runs CROSS_CYCLES-1 down to 0
// TURN   | reversal gap, no grant; latched winner waits TURN_CYCLES cycles
module lemming_bridge_arbiter #(
  parameter int N            = 4,
  parameter int CROSS_CYCLES = 8,
  parameter int TURN_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  lemming_bridge_arbiter_if.slave  bus
);

  localparam int PW    = (N > 1) ? $clog2(N) : 1;
  localparam int MAXC  = (CROSS_CYCLES > TURN_CYCLES) ? CROSS_CYCLES : TURN_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  localparam logic [CNT_W-1:0] CROSS_LOAD = CNT_W'(CROSS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD  = CNT_W'(TURN_CYCLES - 1);
  localparam logic [PW-1:0]    LAST_IDX   = PW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CROSS = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [N-1:0]     grant_q,     grant_d;
  logic             cross_dir_q, cross_dir_d;
  logic [PW-1:0]    ptr_q,       ptr_d;
  logic [PW-1:0]    win_q,       win_d;
  logic             wdir_q,      wdir_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  logic [PW-1:0]    next_ptr;
  logic [PW-1:0]    sel_base;
  logic [PW-1:0]    sel_idx;
  logic             sel_found;
  logic [N-1:0]     sel_onehot;
  logic [N-1:0]     win_onehot;

  assign next_ptr = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;

  // At the end of a crossing the scan starts just past the finishing lemming,
  // so the pointer update and the new selection happen in the same cycle.
  always_comb begin
    int tmp;
    tmp       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_base  = (state_q == CROSS) ? next_ptr : ptr_q;
    for (int k = N - 1; k >= 0; k--) begin
      tmp = int'(sel_base) + k;
      if (tmp >= N) tmp = tmp - N;
      if (bus.req[tmp[PW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = tmp[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_onehot          = '0;
    sel_onehot[sel_idx] = 1'b1;
    win_onehot          = '0;
    win_onehot[win_q]   = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cross_dir_d = cross_dir_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    wdir_d      = wdir_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (sel_found) begin
          state_d     = CROSS;
          win_d       = sel_idx;
          cross_dir_d = bus.dir[sel_idx];
          grant_d     = sel_onehot;
          cnt_d       = CROSS_LOAD;
        end
      end

      CROSS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          ptr_d = next_ptr;
          if (!sel_found) begin
            state_d = IDLE;
            grant_d = '0;
          end else if (bus.dir[sel_idx] == cross_dir_q) begin
            win_d   = sel_idx;
            grant_d = sel_onehot;
            cnt_d   = CROSS_LOAD;
          end else begin
            state_d = TURN;
            win_d   = sel_idx;
            wdir_d  = bus.dir[sel_idx];
            grant_d = '0;
            cnt_d   = TURN_LOAD;
          end
        end
      end

      TURN: begin
        grant_d = '0;
        // A waiting lemming that gives up releases the bridge for re-arbitration.
        if (!bus.req[win_q]) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d     = CROSS;
          grant_d     = win_onehot;
          cross_dir_d = wdir_q;
          cnt_d       = CROSS_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      cross_dir_q <= 1'b0;
      ptr_q       <= '0;
      win_q       <= '0;
      wdir_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cross_dir_q <= cross_dir_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      wdir_q      <= wdir_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.cross_dir = cross_dir_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == CROSS) && (cnt_q == '0);

endmodule

// File: tb/tb_lemming_bridge_arbiter.sv
// Bench for lemming_bridge_arbiter: directed grant traces plus randomized
// traffic, both checked every cycle against a behavioural bridge model.
module tb_lemming_bridge_arbiter;
  localparam int N  = 4;
  localparam int CC = 3;
  localparam int TC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lemming_bridge_arbiter_if #(.N(N)) bus ();

  lemming_bridge_arbiter #(
    .N(N), .CROSS_CYCLES(CC), .TURN_CYCLES(TC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // model: phase 0=bridge empty, 1=someone on the bridge, 2=waiting out a reversal
  int m_phase = 0, m_elapsed = 0, m_owner = 0, m_ptr = 0, m_cdir = 0, m_wdir = 0;
  int w;

  logic [3:0] obs_g [0:31];
  logic       obs_b [0:31];
  logic       obs_d [0:31];
  logic       obs_x [0:31];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_phase = 0; m_elapsed = 0; m_owner = 0; m_ptr = 0; m_cdir = 0; m_wdir = 0;
      end else begin
        case (m_phase)
          0: begin
            w = pick(bus.req, m_ptr);
            if (w >= 0) begin
              m_owner = w; m_cdir = int'(bus.dir[w]); m_phase = 1; m_elapsed = 0;
            end
          end
          1: begin
            if (m_elapsed < CC - 1) m_elapsed++;
            else begin
              m_ptr = (m_owner + 1) % N;
              w = pick(bus.req, m_ptr);
              m_elapsed = 0;
              if (w < 0) m_phase = 0;
              else begin
                m_owner = w;
                if (int'(bus.dir[w]) != m_cdir) begin
                  m_wdir = int'(bus.dir[w]); m_phase = 2;
                end
              end
            end
          end
          default: begin
            if (!bus.req[m_owner]) m_phase = 0;
            else if (m_elapsed < TC - 1) m_elapsed++;
            else begin
              m_phase = 1; m_elapsed = 0; m_cdir = m_wdir;
            end
          end
        endcase
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("model_grant", int'(bus.grant), (m_phase == 1) ? (1 << m_owner) : 0);
      chk("model_busy", int'(bus.busy), (m_phase != 0) ? 1 : 0);
      chk("model_done", int'(bus.done), (m_phase == 1 && m_elapsed == CC - 1) ? 1 : 0);
      chk("model_cross_dir", int'(bus.cross_dir), m_cdir);
    end
  end

  // Cycle 0 is the first edge with reset low; inputs change #1 after an edge.
  task automatic run_scn(input string name, input logic [3:0] r0, input logic [3:0] d0,
                         input int ch1, input logic [3:0] r1,
                         input int ch2, input logic [3:0] r2,
                         input int rc, input string exp_g);
    reset = 1'b1; bus.req = '0; bus.dir = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 bus.req = r0; bus.dir = d0;
    for (int c = 1; c <= exp_g.len(); c++) begin
      @(posedge clk);
      #1;
      if (c == ch1) bus.req = r1;
      if (c == ch2) bus.req = r2;
      if (c == rc) reset = 1'b1;
      if (c == rc + 1) reset = 1'b0;
      @(negedge clk);
      obs_g[c] = bus.grant; obs_b[c] = bus.busy; obs_d[c] = bus.done; obs_x[c] = bus.cross_dir;
    end
    for (int c = 1; c <= exp_g.len(); c++)
      chk($sformatf("%s_grant_c%0d", name, c), int'(obs_g[c]), int'(exp_g[c-1]) - 48);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    bus.req = '0; bus.dir = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_grant", int'(bus.grant), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_cross_dir", int'(bus.cross_dir), 0);

    run_scn("s1", 4'b0001, 4'b0000, 3, 4'b0000, 99, 4'b0000, 99, "11100");
    chk("s1_done_c2", int'(obs_d[2]), 0);
    chk("s1_done_c3", int'(obs_d[3]), 1);
    chk("s1_busy_c4", int'(obs_b[4]), 0);
    chk("s1_cross_dir_c1", int'(obs_x[1]), 0);

    run_scn("s2", 4'b0101, 4'b1111, 99, 4'b0000, 99, 4'b0000, 99, "1114441114");
    chk("s2_cross_dir_c4", int'(obs_x[4]), 1);

    run_scn("s3", 4'b0011, 4'b0010, 99, 4'b0000, 99, 4'b0000, 99, "111002220");
    chk("s3_busy_c4", int'(obs_b[4]), 1);
    chk("s3_cross_dir_c5", int'(obs_x[5]), 0);
    chk("s3_cross_dir_c6", int'(obs_x[6]), 1);
    chk("s3_busy_c9", int'(obs_b[9]), 1);

    run_scn("s4", 4'b1111, 4'b0000, 99, 4'b0000, 99, 4'b0000, 99, "111222444888111");
    dcnt = 0;
    for (int c = 1; c <= 15; c++) dcnt += int'(obs_d[c]);
    chk("s4_done_pulses", dcnt, 5);
    chk("s4_done_c6", int'(obs_d[6]), 1);
    chk("s4_done_c7", int'(obs_d[7]), 0);

    run_scn("s5", 4'b0011, 4'b0010, 4, 4'b0000, 6, 4'b0010, 99, "111000222");
    chk("s5_busy_c5", int'(obs_b[5]), 0);
    chk("s5_cross_dir_c7", int'(obs_x[7]), 1);

    run_scn("s6", 4'b1111, 4'b1111, 99, 4'b0000, 99, 4'b0000, 5, "111220111");
    chk("s6_cross_dir_c4", int'(obs_x[4]), 1);
    chk("s6_busy_c6", int'(obs_b[6]), 0);
    chk("s6_done_c6", int'(obs_d[6]), 0);
    chk("s6_cross_dir_c6", int'(obs_x[6]), 0);
    chk("s6_cross_dir_c7", int'(obs_x[7]), 1);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 9) < 2) bus.req = 4'($urandom);
      if ($urandom_range(0, 9) < 1) bus.dir = 4'($urandom);
      reset = ($urandom_range(0, 399) == 0);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
